hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). It generates stage enables and bubble (NOP) inserts for four cases: RAW data hazards (forwarding-aware), multi-cycle EX operations (mul/div, counter-driven), data-memory wait handshakes, and EX-resolved control redirects. It also keeps a saturating stall-cycle performance counter. It sits beside the pipeline registers and drives their enable and NOP inputs.

Parameters:
ADDR_W, 5, register-address width
FORWARD_EN, 1, 1 = EX/MEM forwarding present (stall only on load-use); 0 = stall on any RAW against EX or MEM
MD_LAT, 4, total cycles a multi-cycle op occupies EX (1 = single-cycle, md_start_ex ignored)
CNT_W, 3, width of the multi-cycle countdown; must satisfy 2^CNT_W >= MD_LAT
PERF_W, 32, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rs1_id / rs2_id  in  ADDR_W  source registers of the instruction in ID
rs1_used / rs2_used  in  1  source operand actually read
rd_ex_addr  in  ADDR_W  destination register of the instruction in EX
rd_ex_we  in  1  EX instruction writes rd
rd_ex_is_load  in  1  EX instruction is a load
rd_mem_addr  in  ADDR_W  destination register of the instruction in MEM
rd_mem_we  in  1  MEM instruction writes rd
md_start_ex  in  1  multi-cycle op in EX, first cycle
mem_req  in  1  MEM stage has an outstanding data access
mem_ready  in  1  data memory completes the access this cycle
redirect_ex  in  1  taken branch or jump resolved in EX
en_pc, en_ifid, en_idex, en_exmem  out  1  stage register enables
nop_ifid, nop_idex, nop_exmem, nop_memwb  out  1  load a bubble into that register
md_busy  out  1  multi-cycle stall in progress
stall_cnt  out  PERF_W  cycles with en_pc=0, saturating

Behaviour:
- State: FSM {RUN, MD_BUSY}, countdown cnt[CNT_W-1:0], stall_cnt. On rst (async): RUN, cnt=0, stall_cnt=0.
- While rst is high: all en_*=0, all nop_*=1, md_busy=0.
- Default outputs (no hazard): all en_*=1, all nop_*=0.
- raw_hit: for each rsN, rsN_used & rsN!=0. With FORWARD_EN=1: rd_ex_we & rd_ex_is_load & rsN==rd_ex_addr. With FORWARD_EN=0: (rd_ex_we & rsN==rd_ex_addr) | (rd_mem_we & rsN==rd_mem_addr).
- Priority, highest first:
  1. mem_wait = mem_req & ~mem_ready: en_pc=en_ifid=en_idex=en_exmem=0, nop_memwb=1, other NOPs 0. FSM and cnt hold.
  2. md_stall = (RUN & md_start_ex & MD_LAT>1) | (MD_BUSY & cnt!=0): en_pc=en_ifid=en_idex=0, nop_exmem=1, md_busy=1. Entering from RUN: next state MD_BUSY, cnt<=MD_LAT-2. In MD_BUSY with cnt!=0: cnt<=cnt-1. In MD_BUSY with cnt==0: no stall (the op advances) and next state RUN. Total stall cycles per op = MD_LAT-1.
  3. redirect_ex, evaluated only when EX advances (en_exmem=1): en_pc=1 (PC loads the target), nop_ifid=1, nop_idex=1. This case overrides raw_hit because the younger instructions are squashed.
  4. raw_hit: en_pc=en_ifid=0, en_idex=1, nop_idex=1.
- A redirect_ex held in EX during mem_wait or md_stall is acted on in the first cycle that EX advances. No separate pending register exists; the EX register holds the branch.
- md_start_ex is ignored while in MD_BUSY.
- stall_cnt: increments on each clock where en_pc=0 and rst=0. It saturates at all-ones.
- All outputs are combinational from the inputs and registered state. There is no output latency.

Test Plan:
- Load-use: FORWARD_EN=1, EX load rd=5, ID rs1=5 used -> 1 cycle en_pc=en_ifid=0, nop_idex=1. The same case with rd_ex_is_load=0 -> no stall. With rs1=0 -> no stall.
- No forwarding: FORWARD_EN=0, MEM writes x7, ID rs2=7 used -> stall. With rs2_used=0 -> no stall.
- Multi-cycle: MD_LAT=4, md_start_ex pulse -> exactly 3 stall cycles with md_busy=1 and nop_exmem=1, 4th cycle all enables 1, state returns to RUN. stall_cnt rises by 3.
- Mem wait inside MD: during MD_BUSY, mem_req=1, mem_ready=0 for 2 cycles -> full freeze, nop_memwb=1, cnt unchanged. Total MD stall becomes 5 cycles.
- Redirect vs RAW: redirect_ex with raw_hit in the same cycle -> en_pc=1, nop_ifid=nop_idex=1, no RAW stall. redirect_ex during mem_wait -> flush occurs only in the cycle mem_ready=1.
- Reset mid-MD: assert rst asynchronously while cnt=1 -> outputs immediately all en=0 and NOPs=1. After release: RUN, stall_cnt=0, no residual stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Generates stage-register enables and bubble inserts for data-memory waits,
// multi-cycle EX ops, EX-resolved redirects and RAW hazards (in that priority
// order). It also keeps a saturating count of cycles in which the PC was held.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   rs1_id/rs2_id, rsN_used   ID-stage source registers and their use flags
//   rd_ex_*                   EX-stage destination, write enable, load flag
//   rd_mem_*                  MEM-stage destination and write enable
//   md_start_ex               first EX cycle of a multi-cycle op
//   mem_req, mem_ready        data-memory access handshake in MEM
//   redirect_ex               taken branch/jump resolved in EX
//   en_pc..en_exmem           stage register enables
//   nop_ifid..nop_memwb       bubble inserts
//   md_busy                   multi-cycle stall in progress
//   stall_cnt                 saturating count of cycles with en_pc=0
module hazard_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int FORWARD_EN = 1,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_id,
  input  logic [ADDR_W-1:0] rs2_id,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [ADDR_W-1:0] rd_ex_addr,
  input  logic              rd_ex_we,
  input  logic              rd_ex_is_load,
  input  logic [ADDR_W-1:0] rd_mem_addr,
  input  logic              rd_mem_we,
  input  logic              md_start_ex,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              redirect_ex,
  output logic              en_pc,
  output logic              en_ifid,
  output logic              en_idex,
  output logic              en_exmem,
  output logic              nop_ifid,
  output logic              nop_idex,
  output logic              nop_exmem,
  output logic              nop_memwb,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  // First busy cycle already counts as a stall, so the countdown starts at MD_LAT-2.
  localparam logic [CNT_W-1:0] CNT_LOAD = (MD_LAT > 1) ? CNT_W'(MD_LAT - 2) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic rs1_live, rs2_live;
  logic hit_fwd, hit_nofwd, raw_hit;
  logic mem_wait, md_stall;

  always_comb begin
    rs1_live  = rs1_used && (rs1_id != '0);
    rs2_live  = rs2_used && (rs2_id != '0);
    // With forwarding only a load in EX cannot supply its result in time.
    hit_fwd   = rd_ex_we && rd_ex_is_load &&
                ((rs1_live && rs1_id == rd_ex_addr) || (rs2_live && rs2_id == rd_ex_addr));
    hit_nofwd = (rd_ex_we  && ((rs1_live && rs1_id == rd_ex_addr)  ||
                               (rs2_live && rs2_id == rd_ex_addr))) ||
                (rd_mem_we && ((rs1_live && rs1_id == rd_mem_addr) ||
                               (rs2_live && rs2_id == rd_mem_addr)));
    raw_hit   = (FORWARD_EN != 0) ? hit_fwd : hit_nofwd;
    mem_wait  = mem_req && !mem_ready;
    md_stall  = (state == RUN && md_start_ex && MD_LAT > 1) ||
                (state == MD_BUSY && cnt != '0);
  end

  always_comb begin
    en_pc     = 1'b1;
    en_ifid   = 1'b1;
    en_idex   = 1'b1;
    en_exmem  = 1'b1;
    nop_ifid  = 1'b0;
    nop_idex  = 1'b0;
    nop_exmem = 1'b0;
    nop_memwb = 1'b0;
    md_busy   = 1'b0;
    if (rst) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      nop_ifid  = 1'b1;
      nop_idex  = 1'b1;
      nop_exmem = 1'b1;
      nop_memwb = 1'b1;
    end else if (mem_wait) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      nop_memwb = 1'b1;
    end else if (md_stall) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      nop_exmem = 1'b1;
      md_busy   = 1'b1;
    end else if (redirect_ex) begin
      // Younger instructions are squashed, so any RAW against them is moot.
      nop_ifid  = 1'b1;
      nop_idex  = 1'b1;
    end else if (raw_hit) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      nop_idex  = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_wait) begin
      if (state == RUN) begin
        if (md_start_ex && MD_LAT > 1) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end else if (cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!en_pc && stall_cnt != '1)
        stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_ex_addr, rd_mem_addr;
  logic       rs1_used, rs2_used, rd_ex_we, rd_ex_is_load, rd_mem_we;
  logic       md_start_ex, mem_req, mem_ready, redirect_ex;

  // a: forwarding, MD_LAT=4; b: no forwarding; s: MD_LAT=1, 2-bit perf counter
  logic a_en_pc, a_en_ifid, a_en_idex, a_en_exmem, a_nop_ifid, a_nop_idex, a_nop_exmem, a_nop_memwb, a_md_busy;
  logic b_en_pc, b_en_ifid, b_en_idex, b_en_exmem, b_nop_ifid, b_nop_idex, b_nop_exmem, b_nop_memwb, b_md_busy;
  logic s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_nop_ifid, s_nop_idex, s_nop_exmem, s_nop_memwb, s_md_busy;
  logic [31:0] a_stall_cnt, b_stall_cnt;
  logic [1:0]  s_stall_cnt;

  int unsigned n_total = 0;
  int unsigned n_fail  = 0;

  // {en_pc,en_ifid,en_idex,en_exmem,nop_ifid,nop_idex,nop_exmem,nop_memwb}
  localparam logic [7:0] V_RUN = 8'b1111_0000;
  localparam logic [7:0] V_RST = 8'b0000_1111;
  localparam logic [7:0] V_MW  = 8'b0000_0001;
  localparam logic [7:0] V_MD  = 8'b0001_0010;
  localparam logic [7:0] V_RDR = 8'b1111_1100;
  localparam logic [7:0] V_RAW = 8'b0011_0100;

  hazard_ctrl #(.FORWARD_EN(1), .MD_LAT(4)) u_a (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_ex_addr(rd_ex_addr), .rd_ex_we(rd_ex_we), .rd_ex_is_load(rd_ex_is_load),
    .rd_mem_addr(rd_mem_addr), .rd_mem_we(rd_mem_we), .md_start_ex(md_start_ex),
    .mem_req(mem_req), .mem_ready(mem_ready), .redirect_ex(redirect_ex),
    .en_pc(a_en_pc), .en_ifid(a_en_ifid), .en_idex(a_en_idex), .en_exmem(a_en_exmem),
    .nop_ifid(a_nop_ifid), .nop_idex(a_nop_idex), .nop_exmem(a_nop_exmem), .nop_memwb(a_nop_memwb),
    .md_busy(a_md_busy), .stall_cnt(a_stall_cnt));

  hazard_ctrl #(.FORWARD_EN(0), .MD_LAT(4)) u_b (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_ex_addr(rd_ex_addr), .rd_ex_we(rd_ex_we), .rd_ex_is_load(rd_ex_is_load),
    .rd_mem_addr(rd_mem_addr), .rd_mem_we(rd_mem_we), .md_start_ex(md_start_ex),
    .mem_req(mem_req), .mem_ready(mem_ready), .redirect_ex(redirect_ex),
    .en_pc(b_en_pc), .en_ifid(b_en_ifid), .en_idex(b_en_idex), .en_exmem(b_en_exmem),
    .nop_ifid(b_nop_ifid), .nop_idex(b_nop_idex), .nop_exmem(b_nop_exmem), .nop_memwb(b_nop_memwb),
    .md_busy(b_md_busy), .stall_cnt(b_stall_cnt));

  hazard_ctrl #(.FORWARD_EN(1), .MD_LAT(1), .PERF_W(2)) u_s (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_ex_addr(rd_ex_addr), .rd_ex_we(rd_ex_we), .rd_ex_is_load(rd_ex_is_load),
    .rd_mem_addr(rd_mem_addr), .rd_mem_we(rd_mem_we), .md_start_ex(md_start_ex),
    .mem_req(mem_req), .mem_ready(mem_ready), .redirect_ex(redirect_ex),
    .en_pc(s_en_pc), .en_ifid(s_en_ifid), .en_idex(s_en_idex), .en_exmem(s_en_exmem),
    .nop_ifid(s_nop_ifid), .nop_idex(s_nop_idex), .nop_exmem(s_nop_exmem), .nop_memwb(s_nop_memwb),
    .md_busy(s_md_busy), .stall_cnt(s_stall_cnt));

  always #5 clk = ~clk;

  wire [7:0] a_vec = {a_en_pc, a_en_ifid, a_en_idex, a_en_exmem, a_nop_ifid, a_nop_idex, a_nop_exmem, a_nop_memwb};
  wire [7:0] b_vec = {b_en_pc, b_en_ifid, b_en_idex, b_en_exmem, b_nop_ifid, b_nop_idex, b_nop_exmem, b_nop_memwb};
  wire [7:0] s_vec = {s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_nop_ifid, s_nop_idex, s_nop_exmem, s_nop_memwb};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_id = '0; rs2_id = '0; rs1_used = 0; rs2_used = 0;
    rd_ex_addr = '0; rd_ex_we = 0; rd_ex_is_load = 0;
    rd_mem_addr = '0; rd_mem_we = 0;
    md_start_ex = 0; mem_req = 0; mem_ready = 0; redirect_ex = 0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("rst_vec", a_vec, V_RST);
    chk("rst_md_busy", a_md_busy, 0);
    chk("rst_stall_cnt", a_stall_cnt, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_a", a_vec, V_RUN);
    chk("idle_b", b_vec, V_RUN);

    // Load-use with forwarding
    rd_ex_addr = 5; rd_ex_we = 1; rd_ex_is_load = 1; rs1_id = 5; rs1_used = 1; #1;
    chk("loaduse_a", a_vec, V_RAW);
    chk("loaduse_b", b_vec, V_RAW);
    next(); rd_ex_is_load = 0; #1;
    chk("nonload_a", a_vec, V_RUN);
    chk("nonload_b", b_vec, V_RAW);
    next(); rd_ex_is_load = 1; rd_ex_addr = 0; rs1_id = 0; #1;
    chk("x0_a", a_vec, V_RUN);
    chk("x0_b", b_vec, V_RUN);
    chk("stall_cnt_lu", a_stall_cnt, 1);

    // RAW against MEM without forwarding
    next(); idle(); rd_mem_addr = 7; rd_mem_we = 1; rs2_id = 7; rs2_used = 1; #1;
    chk("memraw_b", b_vec, V_RAW);
    chk("memraw_a", a_vec, V_RUN);
    next(); rs2_used = 0; #1;
    chk("memraw_unused_b", b_vec, V_RUN);

    // Multi-cycle op, MD_LAT=4 -> 3 stall cycles
    next(); idle(); md_start_ex = 1; #1;
    chk("md0", a_vec, V_MD);
    chk("md0_busy", a_md_busy, 1);
    chk("md_lat1_ignored", s_vec, V_RUN);
    next(); md_start_ex = 0; #1;
    chk("md1", a_vec, V_MD);
    next();
    chk("md2", a_vec, V_MD);
    chk("md2_busy", a_md_busy, 1);
    next();
    chk("md3_done", a_vec, V_RUN);
    chk("md3_busy", a_md_busy, 0);
    chk("stall_cnt_md", a_stall_cnt, 4);

    // Mem wait inside MD: 3 + 2 = 5 stall cycles
    next(); md_start_ex = 1; #1;
    chk("mdw0", a_vec, V_MD);
    next(); md_start_ex = 0; #1;
    chk("mdw1", a_vec, V_MD);
    next(); mem_req = 1; mem_ready = 0; #1;
    chk("mdw_freeze0", a_vec, V_MW);
    next();
    chk("mdw_freeze1", a_vec, V_MW);
    next(); mem_ready = 1; #1;
    chk("mdw_resume", a_vec, V_MD);
    next(); mem_req = 0; mem_ready = 0; #1;
    chk("mdw_done", a_vec, V_RUN);
    chk("stall_cnt_mdw", a_stall_cnt, 9);

    // Redirect overrides RAW
    rd_ex_addr = 3; rd_ex_we = 1; rd_ex_is_load = 1; rs1_id = 3; rs1_used = 1; redirect_ex = 1; #1;
    chk("redir_raw_a", a_vec, V_RDR);
    chk("redir_raw_b", b_vec, V_RDR);

    // Redirect held during mem wait, flushed when memory completes
    next(); idle(); redirect_ex = 1; mem_req = 1; mem_ready = 0; #1;
    chk("redir_mw", a_vec, V_MW);
    next(); mem_ready = 1; #1;
    chk("redir_after_mw", a_vec, V_RDR);
    next(); idle(); #1;
    chk("stall_cnt_redir", a_stall_cnt, 10);
    // u_s stalled 1 (load-use) + 2 + 1 (mem waits) = 4 -> saturated at 3
    chk("sat_stall_cnt", s_stall_cnt, 3);

    // Async reset mid-MD (cnt==1)
    md_start_ex = 1; #1;
    chk("rmd0", a_vec, V_MD);
    next(); md_start_ex = 0;
    next();
    chk("rmd_cnt1", a_vec, V_MD);
    rst = 1'b1; #1;
    chk("rmd_async_vec", a_vec, V_RST);
    chk("rmd_async_busy", a_md_busy, 0);
    chk("rmd_async_cnt", a_stall_cnt, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0; #1;
    chk("rmd_after_vec", a_vec, V_RUN);
    chk("rmd_after_busy", a_md_busy, 0);
    next();
    chk("rmd_after_vec2", a_vec, V_RUN);
    chk("rmd_after_cnt", a_stall_cnt, 0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
